// File: rtl/tank_level_sim_if.sv
// Controller <-> tank-model link: actuator commands and fault control in,
// probe levels, volume and clip pulses out.
`timescale 1ns/1ps
interface tank_level_sim_if #(
  parameter int VOL_W = 8
);
  logic             ve;
  logic             vs;
  logic             bs;
  logic             fault_en;
  logic [1:0]       fault_sel;
  logic             level_l;
  logic             level_m;
  logic             level_h;
  logic [VOL_W-1:0] volume;
  logic             overflow;
  logic             dry_run;

  modport master (
    output ve, vs, bs, fault_en, fault_sel,
    input  level_l, level_m, level_h, volume, overflow, dry_run
  );

  modport slave (
    input  ve, vs, bs, fault_en, fault_sel,
    output level_l, level_m, level_h, volume, overflow, dry_run
  );
endinterface

// File: rtl/tank_level_sim.sv
// Water-tank behavioural model: ticks a volume integrator from valve/pump
// commands and drives hysteretic level probes with optional fault injection.
`timescale 1ns/1ps
module tank_probe #(
  parameter int VOL_W = 8,
  parameter int TH    = 20,
  parameter int HYST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VOL_W-1:0] vol,
  output logic             q
);
  localparam logic [VOL_W-1:0] SET_V = VOL_W'(TH);
  localparam logic [VOL_W-1:0] CLR_V = VOL_W'(TH - HYST);

  // Between CLR_V and SET_V the probe keeps its last state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                q <= 1'b0;
    else if (vol >= SET_V)  q <= 1'b1;
    else if (vol <  CLR_V)  q <= 1'b0;
  end
endmodule

module tank_level_sim #(
  parameter int VOL_W      = 8,
  parameter int CAP        = 200,
  parameter int INIT_VOL   = 0,
  parameter int TICK_DIV   = 1000,
  parameter int FILL_RATE  = 4,
  parameter int DRIP_RATE  = 1,
  parameter int SPRAY_RATE = 2,
  parameter int L_TH       = 20,
  parameter int M_TH       = 100,
  parameter int H_TH       = 180,
  parameter int HYST       = 4
) (
  input  logic clk,
  input  logic rst,
  tank_level_sim_if.slave bus
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SW    = VOL_W + 2;
  typedef logic signed [SW-1:0] sv_t;
  localparam sv_t CAP_S   = sv_t'(CAP);
  localparam sv_t FILL_S  = sv_t'(FILL_RATE);
  localparam sv_t DRIP_S  = sv_t'(DRIP_RATE);
  localparam sv_t SPRAY_S = sv_t'(SPRAY_RATE);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [VOL_W-1:0] vol;
  logic             ov, dr;
  sv_t              nxt;
  logic [2:0]       probe;
  logic             f_l, f_m, f_h;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // Two guard bits keep both the above-CAP and below-zero cases representable.
  always_comb begin
    nxt = sv_t'({2'b00, vol});
    if (bus.ve) nxt = nxt + FILL_S;
    if (bus.vs) nxt = nxt - DRIP_S;
    if (bus.bs) nxt = nxt - SPRAY_S;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vol <= VOL_W'(INIT_VOL);
      ov  <= 1'b0;
      dr  <= 1'b0;
    end else begin
      ov <= 1'b0;
      dr <= 1'b0;
      if (tick) begin
        if (nxt > CAP_S) begin
          vol <= VOL_W'(CAP);
          ov  <= 1'b1;
        end else if (nxt < 0) begin
          vol <= '0;
          dr  <= 1'b1;
        end else begin
          vol <= nxt[VOL_W-1:0];
        end
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_probe
    localparam int TH_I = (i == 0) ? L_TH : (i == 1) ? M_TH : H_TH;
    tank_probe #(.VOL_W(VOL_W), .TH(TH_I), .HYST(HYST)) u_probe (
      .clk (clk),
      .rst (rst),
      .vol (vol),
      .q   (probe[i])
    );
  end

  assign f_l = bus.fault_en && (bus.fault_sel == 2'b01);
  assign f_h = bus.fault_en && (bus.fault_sel == 2'b10);
  assign f_m = bus.fault_en && (bus.fault_sel == 2'b11);

  assign bus.level_l  = probe[0] & ~f_l;
  assign bus.level_m  = probe[1] & ~f_m;
  assign bus.level_h  = probe[2] |  f_h;
  assign bus.volume   = vol;
  assign bus.overflow = ov;
  assign bus.dry_run  = dr;
endmodule

// File: doc/tank_level_sim.md
Name: tank_level_sim

Overview:
- Behavioural water-tank model that sits on the far side of the irrigation controller's sensor interface.
- Consumes the controller's actuator commands: inlet valve, drip valve, sprinkler pump.
- Integrates tank volume over time and drives the three level-probe signals (low/mid/high) back to the controller.
- Offers hysteresis and fault injection so the controller's level decoding, error detection and alarm paths can be exercised closed-loop in simulation and on the board.

Parameters:
VOL_W, 8, width of volume register
CAP, 200, tank capacity in volume units (saturation ceiling, CAP < 2^VOL_W)
INIT_VOL, 0, volume loaded at reset
TICK_DIV, 1000, clock cycles per simulation tick (>=2)
FILL_RATE, 4, units added per tick while ve=1
DRIP_RATE, 1, units removed per tick while vs=1
SPRAY_RATE, 2, units removed per tick while bs=1
L_TH, 20, low-probe threshold
M_TH, 100, mid-probe threshold
H_TH, 180, high-probe threshold (L_TH < M_TH < H_TH <= CAP)
HYST, 4, probe release hysteresis (HYST < L_TH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ve  in  1  inlet valve command (1 = filling)
vs  in  1  drip valve command (1 = draining)
bs  in  1  sprinkler pump command (1 = draining)
fault_en  in  1  enable probe fault injection
fault_sel  in  2  fault mode: 00 none, 01 L stuck-0, 10 H stuck-1, 11 M stuck-0
level_l  out  1  low probe (1 = water at/above L_TH)
level_m  out  1  mid probe
level_h  out  1  high probe
volume  out  VOL_W  current tank volume
overflow  out  1  one-cycle pulse: fill clipped at CAP
dry_run  out  1  one-cycle pulse: drain clipped at 0

Behaviour:
Reset:
- Single clock domain clk; reset is asynchronous and active-high on rst.
- rst=1 immediately forces: prescaler=0, volume=INIT_VOL, probe registers=0, overflow=0, dry_run=0.
- Probe registers reach their correct values on the first clock edge after rst deasserts.
- Reset mid-tick discards the partial tick. The first tick after release completes TICK_DIV cycles later.

Prescaler:
- Counter runs 0..TICK_DIV-1 and wraps to 0.
- tick is internal, high in the cycle where count == TICK_DIV-1.

Volume update (on the tick edge only):
- ve, vs, bs are sampled only in the tick cycle. Changes between ticks are ignored.
- next = volume + (ve?FILL_RATE:0) - (vs?DRIP_RATE:0) - (bs?SPRAY_RATE:0).
- Computed signed at VOL_W+2 bits; all inputs combine in the same tick.
- next > CAP: volume=CAP and overflow=1 for one cycle.
- next < 0: volume=0 and dry_run=1 for one cycle.
- Otherwise volume=next and both pulses are 0.
- Exactly CAP or exactly 0 is not a clip.
- Pulses last one cycle only and are never sticky.

Probe registers (updated every cycle from the registered volume, so latency is 1 cycle after the volume change). For each probe x with threshold TH_x:
- volume >= TH_x: set to 1.
- volume < TH_x - HYST: clear to 0.
- Otherwise: hold.

Outputs:
- Fault injection is combinational on the probe registers, gated by fault_en:
  - 01: level_l=0
  - 10: level_h=1
  - 11: level_m=0
  - Unselected probes pass through unchanged.
- fault_en=0 ignores fault_sel.
- volume is the registered value, unaffected by faults.
- With no fault, probes are always thermometer-coded (H implies M implies L).

Test Plan:
Use TICK_DIV=4 and default parameters unless stated.
1. Fill: reset, ve=1, vs=bs=0 -> volume +4 every 4 cycles. level_l=1 one cycle after volume=20 (tick 5), level_m after volume=100 (tick 25), level_h after volume=180 (tick 45). volume=200 at tick 50 with no overflow. Tick 51: volume stays 200 and overflow pulses exactly 1 cycle.
2. Hysteresis: start at volume=100 with level_m=1, then bs=1 only -> level_m stays 1 at 98 and 96. level_m clears one cycle after volume=94.
3. Simultaneous commands: ve=vs=bs=1 from volume=50 -> volume 51, 52, 53 on successive ticks. No pulses.
4. Dry run: volume=1, vs=0, bs=1 -> next tick volume=0 and dry_run pulses 1 cycle. Following tick: volume=0 and dry_run pulses again.
5. Fault injection:
   - volume=150, fault_en=1, fault_sel=01 -> L/M/H = 0/1/0.
   - fault_sel=11 at volume=190 -> 1/0/1.
   - fault_sel=10 at volume=50 -> 1/0/1.
   - fault_en=0 -> true levels restored in the same cycle.
6. Async reset: assert rst for 1 ns mid-tick at volume=120 -> volume=0, all probes 0, no clock edge needed. After release, first volume change occurs exactly 4 cycles later.
